// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types for the bit-serial adder.
//   sa_state_t : controller state encoding (IDLE, SHIFT, DONE).
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_t;

endpackage

// File: rtl/full_adder.sv
// full_adder
//   Single-bit combinational full adder cell.
//   a, b  : addend bits
//   c     : carry-in
//   sum   : a ^ b ^ c
//   carry : majority(a, b, c)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: reuses one full_adder to add two WIDTH-bit operands,
//   one bit per clock, LSB first.
//   clk    : clock, all state on rising edge
//   rst_n  : synchronous active-low reset
//   start  : request an addition, sampled only in IDLE
//   a, b   : operands, captured on the accepted start
//   cin    : carry-in, captured on the accepted start
//   busy   : high in SHIFT or DONE
//   done   : one-cycle pulse, sum/cout final
//   sum    : result, held until the next accepted start
//   cout   : final carry-out, held with sum
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic fa_sum;
    logic fa_carry;

    full_adder u_full_adder (
        .a     (sa_q[0]),
        .b     (sb_q[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                end
            end
            SHIFT: begin
                // Result enters at the MSB so bit 0 lands at position 0
                // after WIDTH shifts.
                sum_d            = sum_q >> 1;
                sum_d[WIDTH-1]   = fa_sum;
                sa_d             = sa_q >> 1;
                sb_d             = sb_q >> 1;
                carry_d          = fa_carry;
                cnt_d            = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cout_d  = fa_carry;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int errors = 0;
    int checks = 0;

    serial_adder #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Launch one operation with a single-cycle start and wait for done.
    // done_at is the number of edges after the start edge (-1 on timeout).
    task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic ic, output int done_at, output int busy_cnt);
        a = ia; b = ib; cin = ic; start = 1'b1;
        tick;
        start = 1'b0; a = ~ia; b = ~ib; cin = ~ic;
        busy_cnt = busy ? 1 : 0;
        done_at = -1;
        for (int k = 1; k <= 30; k++) begin
            tick;
            if (busy) busy_cnt++;
            if (done) begin
                done_at = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        tick; tick;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b required 0 0", busy, done);
        end
        checks++;
        if (sum !== 8'h00 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: sum=%h cout=%b required 00 0", sum, cout);
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        int d, bc;
        run_op(8'h3C, 8'h42, 1'b0, d, bc);
        checks++;
        if (d !== 8) begin
            errors++;
            $display("FAIL basic_done_latency: got %0d required 8", d);
        end
        checks++;
        if (bc !== 9) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d required 9", bc);
        end
        checks++;
        if (sum !== 8'h7E || cout !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: sum=%h cout=%b required 7e 0", sum, cout);
        end
        tick;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_after: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_ripple;
        int d, bc;
        run_op(8'hFF, 8'h01, 1'b0, d, bc);
        checks++;
        if (d !== 8 || sum !== 8'h00 || cout !== 1'b1) begin
            errors++;
            $display("FAIL ripple: done_at=%0d sum=%h cout=%b required 8 00 1", d, sum, cout);
        end
        tick;
    endtask

    task automatic test_carry_in;
        int d, bc;
        run_op(8'hA5, 8'h5A, 1'b1, d, bc);
        checks++;
        if (d !== 8 || sum !== 8'h00 || cout !== 1'b1) begin
            errors++;
            $display("FAIL carry_in: done_at=%0d sum=%h cout=%b required 8 00 1", d, sum, cout);
        end
        tick; tick; tick;
        checks++;
        if (busy !== 1'b0 || sum !== 8'h00 || cout !== 1'b1) begin
            errors++;
            $display("FAIL carry_in_hold: busy=%b sum=%h cout=%b required 0 00 1",
                     busy, sum, cout);
        end
    endtask

    task automatic test_start_while_busy;
        int d;
        int extra;
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        d = -1;
        for (int k = 1; k <= 30; k++) begin
            if (k == 3) begin
                start = 1'b1; a = 8'h01; b = 8'h01;
            end else begin
                start = 1'b0;
            end
            tick;
            if (done) begin
                d = k;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (d !== 8 || sum !== 8'h30 || cout !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_result: done_at=%0d sum=%h cout=%b required 8 30 0",
                     d, sum, cout);
        end
        extra = 0;
        for (int k = 0; k < 14; k++) begin
            tick;
            if (done || busy) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL busy_start_extra: %0d busy/done cycles required 0", extra);
        end
    endtask

    task automatic test_reset_mid;
        int d, bc;
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick; tick;
        // Now in the SHIFT cycle that computes bit 4.
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b required 0 0 00 0",
                     busy, done, sum, cout);
        end
        run_op(8'h80, 8'h80, 1'b0, d, bc);
        checks++;
        if (d !== 8 || sum !== 8'h00 || cout !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_after: done_at=%0d sum=%h cout=%b required 8 00 1",
                     d, sum, cout);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int n_done;
        int pos [3];
        a = 8'h0F; b = 8'hF0; cin = 1'b0; start = 1'b1;
        n_done = 0;
        for (int t = 1; t <= 40; t++) begin
            if (t > 25) start = 1'b0;
            tick;
            if (done) begin
                if (n_done < 3) pos[n_done] = t;
                n_done++;
                checks++;
                if (sum !== 8'hFF || cout !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_result: pulse %0d sum=%h cout=%b required ff 0",
                             n_done, sum, cout);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (n_done !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d pulses required 3", n_done);
        end else begin
            checks++;
            if (pos[0] !== 9 || pos[1] !== 19 || pos[2] !== 29) begin
                errors++;
                $display("FAIL b2b_spacing: pulses at %0d %0d %0d required 9 19 29",
                         pos[0], pos[1], pos[2]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        test_reset;
        test_basic;
        test_ripple;
        test_carry_in;
        test_start_while_busy;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
